pwm_gpio_bank: RTL and testbench
================================

// Module: pwm_gpio_bank
// PURPOSE
//  Parametrised successor to the top-level single GPIO/PWM path: a bank of NCH PWM channels.
//  - Channel registers are written over the byte-wide ui_in/uio_in strobe interface.
//  - Duty updates are glitch-free: shadow registers, copied to active at period wrap.
//  - Adds a clock prescaler, a per-channel enable and polarity, registered readback and a
//    period strobe for the 7-seg/animation logic.
//  - Sits between the core top's input decode and uo_out.
// PARAMETERS
//  NCH      4  number of PWM channels (1..8)
//  DW       8  PWM resolution in bits; period = 2**DW ticks
//  AW       3  register address width; must satisfy 2**AW >= NCH+3
//  PRESC_W  4  prescaler register width
// PORTS
//  clk           in   1        system clock
//  rst_n         in   1        asynchronous reset, active-low
//  ena           in   1        block enable; when 0, writes are ignored and PWM keeps running
//  wr_en         in   1        write strobe, level; the write fires on its rising edge
//  addr          in   AW       register address
//  wdata         in   DW       write data
//  rdata         out  DW       registered readback of addr
//  pwm_out       out  NCH      PWM outputs, registered
//  period_stb    out  1        one-cycle pulse on each PWM counter wrap
// BEHAVIOUR
//  Register map (writes use wdata LSBs):
//   - 0..NCH-1: DUTY_SH[i].
//   - NCH: EN mask [NCH-1:0].
//   - NCH+1: PRESC [PRESC_W-1:0].
//   - NCH+2: POL mask [NCH-1:0].
//   - Any other addr: write ignored, rdata=0.
//  Reset (async, rst_n=0):
//   - All registers, counters, duty_act, the wr_en history flop, rdata, pwm_out and
//     period_stb go to 0.
//  Write:
//   - wr_q <= wr_en every cycle; the write fires when wr_en & ~wr_q & ena.
//   - Holding wr_en high gives exactly one write.
//   - A rising edge with ena=0 is lost: it is not replayed when ena returns.
//  Readback:
//   - rdata <= reg[addr] each cycle, giving 1-cycle latency.
//   - Read values are zero-extended to DW.
//   - For DUTY addresses rdata returns the shadow value.
//  Prescaler:
//   - pcnt counts 0..PRESC; tick=1 when pcnt==PRESC, then pcnt<=0.
//   - PRESC=0 gives tick every cycle.
//   - Writing PRESC resets pcnt to 0.
//  PWM counter:
//   - cnt (DW bits) increments on tick and wraps 2**DW-1 -> 0.
//   - wrap = tick & cnt==all-ones.
//   - period_stb <= wrap, so it is registered and lags wrap by 1 cycle.
//  Duty load:
//   - On wrap, duty_act[i] <= DUTY_SH[i] for all i.
//   - The value loaded is the pre-write shadow value, so a write on the wrap cycle takes
//     effect at the next wrap.
//   - Writing EN with bit i going 0->1 loads duty_act[i] <= DUTY_SH[i] immediately.
//  Output:
//   - pwm_out[i] <= EN[i] ? ((cnt < duty_act[i]) ^ POL[i]) : POL[i].
//   - Duty 0 gives a constant inactive level.
//   - Duty 2**DW-1 is active for 2**DW-1 of 2**DW ticks; 100% is not reachable, by design.
//   - A disabled channel holds its idle level, POL[i].
//  ena=0:
//   - Prescaler, counter and outputs continue unchanged; only writes are blocked.
//  Reset mid-period:
//   - Everything clears; after release, cnt restarts at 0 with duty_act=0 (outputs inactive).
// TESTING
//  1. Reset, wr DUTY0=0x40, EN=0x1, PRESC=0 -> pwm_out[0] high 64 of 256 cycles; period_stb
//     every 256 cycles.
//  2. Mid-period, wr DUTY0=0xC0 -> current period keeps 64-cycle high; next period 192.
//     Also a write on the wrap cycle itself -> takes effect one period later.
//  3. PRESC=3 -> period_stb every 1024 clks. Duty 0 and duty 0xFF ->
//     - duty 0: never high;
//     - duty 0xFF: high 255/256 ticks.
//  4. Hold wr_en high 5 cycles with wdata changing -> only the first value written.
//     ena=0 edge -> rdata unchanged.
//  5. POL=0x3, EN=0x1 -> ch1 idle high; ch0 inverted duty.
//     Readback of each addr after 1 cycle matches; addr 7 -> rdata=0.
//  6. Assert rst_n=0 mid-period -> all outputs 0 asynchronously, without waiting for clk.
//     Release -> no pulse until rewritten.

Source files
------------

// File: rtl/pwm_gpio_bank.sv
// -----------------------------------------------------------------------------
// pwm_gpio_bank
//
// Bank of NCH PWM channels behind a byte-wide register strobe interface.
// Duty writes land in shadow registers and are copied to the active duty at
// each PWM counter wrap, so a running period is never cut short or stretched.
// A shared prescaler slows the PWM tick; each channel has an enable and a
// polarity bit.
//
// Register map (writes use the LSBs of wdata):
//   0 .. NCH-1 : DUTY shadow for channel i
//   NCH        : EN mask   [NCH-1:0]
//   NCH+1      : PRESC     [PRESC_W-1:0]
//   NCH+2      : POL mask  [NCH-1:0]
//   others     : writes ignored, read as 0
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous reset, active-low
//   ena        block enable; 0 blocks writes only, PWM keeps running
//   wr_en      write strobe (level); a write fires on its rising edge
//   addr       register address
//   wdata      write data
//   rdata      registered readback of addr (1-cycle latency)
//   pwm_out    registered PWM outputs
//   period_stb one-cycle pulse, one cycle after each PWM counter wrap
// -----------------------------------------------------------------------------
module pwm_gpio_bank #(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int PRESC_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           wr_en,
    input  logic [AW-1:0]  addr,
    input  logic [DW-1:0]  wdata,
    output logic [DW-1:0]  rdata,
    output logic [NCH-1:0] pwm_out,
    output logic           period_stb
);

    localparam logic [AW-1:0] A_EN    = AW'(NCH);
    localparam logic [AW-1:0] A_PRESC = AW'(NCH + 1);
    localparam logic [AW-1:0] A_POL   = AW'(NCH + 2);

    logic               wr_q;
    logic [DW-1:0]      duty_sh  [NCH];
    logic [DW-1:0]      duty_act [NCH];
    logic [NCH-1:0]     en_q;
    logic [NCH-1:0]     pol_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] pcnt;
    logic [DW-1:0]      cnt;

    logic               wr_fire;
    logic               en_wr;
    logic               presc_wr;
    logic               pol_wr;
    logic [NCH-1:0]     en_rise;
    logic               tick;
    logic               wrap;
    logic [DW-1:0]      rd_nxt;
    logic [NCH-1:0]     pwm_nxt;

    // Edge-detected write: holding wr_en high writes once, and an edge that
    // arrives while ena=0 is consumed by wr_q and never replayed.
    assign wr_fire  = wr_en & ~wr_q & ena;
    assign en_wr    = wr_fire & (addr == A_EN);
    assign presc_wr = wr_fire & (addr == A_PRESC);
    assign pol_wr   = wr_fire & (addr == A_POL);
    assign en_rise  = en_wr ? (wdata[NCH-1:0] & ~en_q) : '0;

    assign tick = (pcnt == presc_q);
    assign wrap = tick & (cnt == '1);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= 1'b0;
        end else begin
            wr_q <= wr_en;
        end
    end

    // NOTE: the duty arrays are small register files, not RAM, so they take
    // the async reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) duty_sh[i] <= '0;
            en_q    <= '0;
            pol_q   <= '0;
            presc_q <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NCH; i++) begin
                if (addr == AW'(i)) duty_sh[i] <= wdata;
            end
            if (en_wr)    en_q    <= wdata[NCH-1:0];
            if (presc_wr) presc_q <= wdata[PRESC_W-1:0];
            if (pol_wr)   pol_q   <= wdata[NCH-1:0];
        end
    end

    // Active duty reloads from the pre-write shadow, so a duty write on the
    // wrap cycle only shows up one period later. A freshly enabled channel
    // picks up its shadow immediately rather than waiting for the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) duty_act[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wrap || en_rise[i]) duty_act[i] <= duty_sh[i];
            end
        end
    end

    // Prescaler; a PRESC write restarts it so the new ratio starts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (presc_wr || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // PWM counter wraps naturally at 2**DW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (addr == AW'(i)) rd_nxt = duty_sh[i];
        end
        if (addr == A_EN)    rd_nxt[NCH-1:0]     = en_q;
        if (addr == A_PRESC) rd_nxt[PRESC_W-1:0] = presc_q;
        if (addr == A_POL)   rd_nxt[NCH-1:0]     = pol_q;
    end

    // Duty 0 never goes active; the top duty value leaves one inactive tick,
    // so 100% is unreachable. Disabled channels sit at their idle level POL.
    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_nxt[i] = en_q[i] ? ((cnt < duty_act[i]) ^ pol_q[i]) : pol_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata      <= '0;
            pwm_out    <= '0;
            period_stb <= 1'b0;
        end else begin
            rdata      <= rd_nxt;
            pwm_out    <= pwm_nxt;
            period_stb <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_gpio_bank.sv
// -----------------------------------------------------------------------------
// tb_pwm_gpio_bank
//
// Self-checking bench for pwm_gpio_bank (NCH=4, DW=8, AW=3, PRESC_W=4).
// A behavioural model (register file array + modular counters) tracks the
// expected outputs every cycle; a vector table checks register readback, and
// hand-written sequences measure duty/period over whole PWM periods.
// -----------------------------------------------------------------------------
module tb_pwm_gpio_bank;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       wr_en;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [3:0] pwm_out;
    logic       period_stb;

    pwm_gpio_bank #(
        .NCH     (4),
        .DW      (8),
        .AW      (3),
        .PRESC_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .wr_en      (wr_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .pwm_out    (pwm_out),
        .period_stb (period_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_reg: 0..3 duty shadow, 4 EN, 5 PRESC, 6 POL, 7 unmapped (always 0)
    int m_reg [8];
    int m_act [4];
    int m_pcnt;
    int m_cnt;
    bit m_wrq;
    int e_rd;
    int e_pwm;
    int e_stb;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        for (int i = 0; i < 4; i++) m_act[i] = 0;
        m_pcnt = 0;
        m_cnt  = 0;
        m_wrq  = 0;
        e_rd   = 0;
        e_pwm  = 0;
        e_stb  = 0;
    endfunction

    function automatic void model_step(input bit w, input int a, input int d, input bit e);
        bit fire;
        bit tck;
        bit wrp;
        int old_en;
        fire   = w && !m_wrq && e;
        tck    = (m_pcnt == m_reg[5]);
        wrp    = tck && (m_cnt == 255);
        old_en = m_reg[4];
        // outputs from the state before this edge
        e_pwm = 0;
        for (int i = 0; i < 4; i++) begin
            int pol_b;
            int on;
            pol_b = (m_reg[6] >> i) & 1;
            if (((old_en >> i) & 1) != 0) on = (m_cnt < m_act[i]) ? 1 - pol_b : pol_b;
            else                          on = pol_b;
            e_pwm |= on << i;
        end
        e_rd  = m_reg[a];
        e_stb = wrp ? 1 : 0;
        // state update
        if (wrp) for (int i = 0; i < 4; i++) m_act[i] = m_reg[i];
        m_pcnt = tck ? 0 : m_pcnt + 1;
        if (tck) m_cnt = (m_cnt + 1) % 256;
        if (fire) begin
            if (a < 4) m_reg[a] = d;
            else if (a == 4) begin
                for (int i = 0; i < 4; i++)
                    if (((d >> i) & 1) != 0 && ((old_en >> i) & 1) == 0) m_act[i] = m_reg[i];
                m_reg[4] = d & 'hF;
            end else if (a == 5) begin
                m_reg[5] = d & 'hF;
                m_pcnt   = 0;
            end else if (a == 6) m_reg[6] = d & 'hF;
        end
        m_wrq = w;
    endfunction

    // ---------------- stimulus helpers ----------------
    int hi0;
    int hi1;
    int stb_n;

    task automatic clear_counts();
        hi0 = 0; hi1 = 0; stb_n = 0;
    endtask

    // Called at a negedge: drive, clock, compare at the next negedge.
    task automatic do_cycle(input logic w, input logic [2:0] a, input logic [7:0] d, input logic e);
        wr_en = w; addr = a; wdata = d; ena = e;
        @(posedge clk);
        model_step(w, int'(a), int'(d), e);
        @(negedge clk);
        check("pwm_out", int'(pwm_out), e_pwm);
        check("rdata", int'(rdata), e_rd);
        check("period_stb", int'(period_stb), e_stb);
        hi0   += int'(pwm_out[0]);
        hi1   += int'(pwm_out[1]);
        stb_n += int'(period_stb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 3'd0, 8'h00, 1'b1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        do_cycle(1'b1, a, d, 1'b1);
        do_cycle(1'b0, a, d, 1'b1);
    endtask

    task automatic sync_stb(input int limit);
        int n;
        bit seen;
        n = 0; seen = 0;
        while (!seen && n < limit) begin
            idle(1);
            n++;
            seen = period_stb;
        end
        check("sync_stb_timeout", int'(seen), 1);
    endtask

    task automatic async_reset();
        wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_pwm", int'(pwm_out), 0);
        check("rst_async_rdata", int'(rdata), 0);
        check("rst_async_stb", int'(period_stb), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] addr;
        logic [7:0] wdata;
        logic       ena;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n;
        rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
        model_reset();
        #1;
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_rdata", int'(rdata), 0);
        check("reset_stb", int'(period_stb), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Register readback table: write, then read back one cycle later.
        vecs[0] = '{3'd0, 8'h40, 1'b1, 8'h40};
        vecs[1] = '{3'd1, 8'hA5, 1'b1, 8'hA5};
        vecs[2] = '{3'd4, 8'hFF, 1'b1, 8'h0F};
        vecs[3] = '{3'd5, 8'h37, 1'b1, 8'h07};
        vecs[4] = '{3'd6, 8'hF3, 1'b1, 8'h03};
        vecs[5] = '{3'd7, 8'h55, 1'b1, 8'h00};
        vecs[6] = '{3'd2, 8'h99, 1'b0, 8'h00};
        vecs[7] = '{3'd3, 8'h12, 1'b1, 8'h12};
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].ena);
            do_cycle(1'b0, vecs[i].addr, vecs[i].wdata, 1'b1);
            check($sformatf("tbl_rd[%0d]", i), int'(rdata), int'(vecs[i].exp_rd));
        end

        // 1: basic 64/256 duty, strobe once per 256 cycles.
        async_reset();
        wr(3'd0, 8'h40);
        wr(3'd4, 8'h01);
        sync_stb(600);
        clear_counts();
        idle(256);
        check("t1_high_64", hi0, 64);
        check("t1_stb_once", stb_n, 1);

        // 2: mid-period write keeps the current period, applies next one.
        clear_counts();
        idle(50);
        wr(3'd0, 8'hC0);
        idle(204);
        check("t2_cur_64", hi0, 64);
        clear_counts();
        idle(256);
        check("t2_next_192", hi0, 192);
        // write landing exactly on the wrap edge
        idle(255);
        do_cycle(1'b1, 3'd0, 8'h20, 1'b1);
        clear_counts();
        do_cycle(1'b0, 3'd0, 8'h20, 1'b1);
        idle(255);
        check("t2_wrapwr_still_192", hi0, 192);
        clear_counts();
        idle(256);
        check("t2_wrapwr_then_32", hi0, 32);

        // 3: prescaler 3 -> 1024-cycle period; duty extremes.
        wr(3'd5, 8'h03);
        sync_stb(3000);
        n = 0;
        do begin
            idle(1);
            n++;
        end while (!period_stb && n < 3000);
        check("t3_period_1024", n, 1024);
        wr(3'd0, 8'h00);
        sync_stb(3000);
        clear_counts();
        idle(1024);
        check("t3_duty0_never", hi0, 0);
        wr(3'd0, 8'hFF);
        sync_stb(3000);
        clear_counts();
        idle(1024);
        check("t3_duty_ff_1020", hi0, 1020);
        wr(3'd5, 8'h00);

        // 4: held strobe writes once; edge under ena=0 is lost.
        do_cycle(1'b1, 3'd1, 8'h11, 1'b1);
        do_cycle(1'b1, 3'd1, 8'h22, 1'b1);
        do_cycle(1'b1, 3'd1, 8'h33, 1'b1);
        do_cycle(1'b1, 3'd1, 8'h44, 1'b1);
        do_cycle(1'b1, 3'd1, 8'h55, 1'b1);
        do_cycle(1'b0, 3'd1, 8'h66, 1'b1);
        check("t4_held_first_only", int'(rdata), 'h11);
        do_cycle(1'b1, 3'd1, 8'h77, 1'b0);
        do_cycle(1'b1, 3'd1, 8'h77, 1'b1);
        do_cycle(1'b0, 3'd1, 8'h77, 1'b1);
        check("t4_ena0_lost", int'(rdata), 'h11);

        // 5: polarity; ch1 disabled idles high, ch0 inverted.
        wr(3'd0, 8'h40);
        wr(3'd6, 8'h03);
        wr(3'd4, 8'h01);
        sync_stb(600);
        clear_counts();
        idle(256);
        check("t5_ch0_inverted_192", hi0, 192);
        check("t5_ch1_idle_high", hi1, 256);

        // 6: async reset mid-period, then silence until rewritten.
        idle(100);
        async_reset();
        clear_counts();
        idle(512);
        check("t6_no_pulse_after_rst", hi0 + hi1, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     8'($urandom_range(0, 255)), ($urandom_range(0, 9) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
